// File: rtl/ex_muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine for the EX stage, STEP bits per RUN cycle.
// Latency N+2 cycles from start (N = WIDTH/STEP); with MULDIV_EARLY_OUT_EN, multiplies may finish early.
// Backpressure: stall freezes the EX pipeline register from the start cycle through FIX; flush aborts.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Latched operation context. Magnitudes are kept unsigned; signs are re-applied in FIX.
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;     // multiplier (shifted right as digits retire) or divisor
  logic [2*WIDTH-1:0] acc;       // product, or {remainder, quotient/dividend shift register}
  logic [CW-1:0]      cnt;

  // Operand decode at the request boundary.
  logic               in_sign_a;
  logic               in_sign_b;
  logic [WIDTH-1:0]   in_a_mag;
  logic [WIDTH-1:0]   in_b_mag;

  // One RUN iteration for each kind of operation.
  logic [2*WIDTH-1:0] mc_ext;
  logic [2*WIDTH-1:0] dig_ext;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [2*WIDTH-1:0] div_nxt;
  logic [WIDTH:0]     rem_t;
  logic [WIDTH-1:0]   quo_t;
  int                 shamt;
  logic               last_iter;

  // Sign-corrected result presented by FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_lo;
  logic [WIDTH-1:0]   fix_hi;
  logic               fix_dz;

  // Signs only matter for the signed opcodes (op[0] set); the most negative value maps to itself,
  // which is exactly its unsigned magnitude.
  always_comb begin
    in_sign_a = op[0] & a[WIDTH-1];
    in_sign_b = op[0] & b[WIDTH-1];
    in_a_mag  = in_sign_a ? -a : a;
    in_b_mag  = in_sign_b ? -b : b;
  end

  // Shift-add multiply: add |a| * (next STEP multiplier bits) at the current digit position.
  always_comb begin
    mc_ext             = {{WIDTH{1'b0}}, a_mag};
    dig_ext            = '0;
    dig_ext[STEP-1:0]  = b_mag[STEP-1:0];
    shamt              = int'(cnt) * STEP;
    mul_nxt            = acc + ((mc_ext * dig_ext) << shamt);
  end

  // Restoring divide: STEP shift/compare/subtract rounds per cycle, quotient bits enter at the LSB.
  always_comb begin
    rem_t = {1'b0, acc[2*WIDTH-1:WIDTH]};
    quo_t = acc[WIDTH-1:0];
    for (int i = 0; i < STEP; i++) begin
      rem_t = {rem_t[WIDTH-1:0], quo_t[WIDTH-1]};
      quo_t = {quo_t[WIDTH-2:0], 1'b0};
      if (rem_t >= {1'b0, b_mag}) begin
        rem_t    = rem_t - {1'b0, b_mag};
        quo_t[0] = 1'b1;
      end
    end
    div_nxt = {rem_t[WIDTH-1:0], quo_t};
  end

  // Decide whether the current RUN cycle is the final one.
  always_comb begin
    last_iter = (cnt == CW'(N - 1));
`ifdef MULDIV_EARLY_OUT_EN
    // Once no multiplier bits remain beyond this digit the product is already complete.
    if (!is_div && ((b_mag >> STEP) == '0)) begin
      last_iter = 1'b1;
    end
`endif
  end

  // Sign correction: product negated when signs differ; quotient truncates toward zero,
  // remainder follows the dividend. Divide by zero overrides with all-ones / original dividend.
  // The -2^(W-1) / -1 case falls out naturally: |q| = 2^(W-1) keeps its bit pattern, remainder 0.
  always_comb begin
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    fix_lo   = prod_fix[WIDTH-1:0];
    fix_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fix_dz   = 1'b0;
    if (is_div) begin
      if (b_mag == '0) begin
        fix_lo = '1;
        fix_hi = sign_a ? -a_mag : a_mag;
        fix_dz = 1'b1;
      end else begin
        fix_lo = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and stall decode; flush only aborts work that has not yet completed.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          state_nxt = RUN;
          stall     = 1'b1;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else if (last_iter) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN) || (state == FIX);
  assign done = (state == DONE);

  // Datapath: capture operands on accept, iterate in RUN, publish results on leaving FIX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      a_mag       <= '0;
      b_mag       <= '0;
      acc         <= '0;
      cnt         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            is_div <= op[1];
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            acc    <= op[1] ? {{WIDTH{1'b0}}, in_a_mag} : '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (flush) begin
            cnt <= '0;
          end else begin
            acc <= is_div ? div_nxt : mul_nxt;
            if (!is_div) begin
              b_mag <= b_mag >> STEP;
            end
            cnt <= last_iter ? '0 : cnt + CW'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            result_lo   <= fix_lo;
            result_hi   <= fix_hi;
            div_by_zero <= fix_dz;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: randomized and directed ops against an arithmetic model.
// Expected results and completion cycles are queued at issue; a monitor checks them on done.
// Also exercises flush, start-while-busy, flush-with-start and reset mid-operation.
module tb_ex_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 1;
  localparam int N     = WIDTH / STEP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        div_by_zero;

  ex_muldiv_unit #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall(stall), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          due;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          stall_run = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;
  logic        last_dz = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference results straight from integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      sx;
    longint      sy;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    e.dz = 1'b0;
    e.due = 0;
    e.lat = 0;
    case (o)
      2'd0: p = {32'b0, x} * {32'b0, y};
      2'd1: p = sx * sy;
      2'd2: p = (y == 0) ? 64'd0 : {32'(x % y), 32'(x / y)};
      default: begin
        p = '0;
        if (y != 0) begin
          p[31:0]  = 32'(sx / sy);
          p[63:32] = 32'(sx % sy);
        end
      end
    endcase
    e.lo = p[31:0];
    e.hi = p[63:32];
    if (o[1] && y == 0) begin
      e.lo = 32'hFFFF_FFFF;
      e.hi = x;
      e.dz = 1'b1;
    end
    return e;
  endfunction

  // Cycles from the start cycle to the done cycle.
  function automatic int exp_lat(input logic [1:0] o, input logic [31:0] y);
    int          digits;
    logic [63:0] mag;
    digits = N;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      mag = (o[0] && y[31]) ? {32'b0, -y} : {32'b0, y};
      digits = 1;
      while (((mag >> (digits * STEP)) != 0) && digits < N) digits++;
    end
`else
    mag = {32'b0, y};
    if (mag == 64'hFFFF_FFFF_FFFF_FFFF) digits = N;
`endif
    return digits + 2;
  endfunction

  // Monitor: on every done, pop the oldest expectation and compare result, timing and stall span.
  always @(negedge clk) begin
    if (stall) begin
      stall_run++;
    end else begin
      if (done) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("result_lo", {32'b0, result_lo}, {32'b0, e.lo});
          check("result_hi", {32'b0, result_hi}, {32'b0, e.hi});
          check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dz});
          check("done_cycle", 64'(cyc), 64'(e.due));
          check("stall_cycles", 64'(stall_run), 64'(e.lat));
        end
      end
      stall_run = 0;
    end
  end

  task automatic wait_done();
    int i;
    i = 0;
    while (!done && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
  endtask

  // Issue one op; optionally keep start high (with changing operands) for hold RUN cycles.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1;
    e = model(o, x, y);
    lat = exp_lat(o, y);
    e.due = cyc + lat;
    e.lat = lat;
    sb_q.push_back(e);
    last_lo = e.lo; last_hi = e.hi; last_dz = e.dz;
    @(posedge clk); #1;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_lo", {32'b0, result_lo}, 64'd0);
    check("rst_hi", {32'b0, result_hi}, 64'd0);
    check("rst_dz", {63'b0, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_stall", {63'b0, stall}, 64'd0);

    // Directed cases.
    do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("mulu_max_hi", {32'b0, result_hi}, 64'hFFFF_FFFE);
    check("mulu_max_lo", {32'b0, result_lo}, 64'h0000_0001);
    do_op(2'd1, -32'sd7, 32'd6, 0);
    check("mul_neg_lo", {32'b0, result_lo}, 64'hFFFF_FFD6);
    do_op(2'd3, -32'sd7, 32'd2, 0);
    check("div_neg_rem", {32'b0, result_hi}, 64'hFFFF_FFFF);
    do_op(2'd2, 32'd100, 32'd0, 0);
    check("divu_zero_lo", {32'b0, result_lo}, 64'hFFFF_FFFF);
    do_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf_lo", {32'b0, result_lo}, 64'h8000_0000);
    do_op(2'd3, -32'sd7, 32'd0, 0);
    do_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(2'd0, 32'd9, 32'd3, 0);
    check("mulu_small_lo", {32'b0, result_lo}, 64'd27);
    do_op(2'd1, 32'd12345, 32'd0, 0);

    // start held high during RUN must not disturb the op in flight.
    do_op(2'd2, 32'd1000, 32'd7, 5);

    // Flush in RUN: back to IDLE, no done, results untouched, next start accepted right away.
    @(posedge clk); #1;
    op = 2'd2; a = 32'd5000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    check("flush_lo_kept", {32'b0, result_lo}, {32'b0, last_lo});
    check("flush_hi_kept", {32'b0, result_hi}, {32'b0, last_hi});
    check("flush_dz_kept", {63'b0, div_by_zero}, {63'b0, last_dz});
    do_op(2'd3, 32'hFFFF_FF00, 32'd9, 0);

    // Flush together with start in IDLE drops the request.
    @(posedge clk); #1;
    op = 2'd0; a = 32'd4; b = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", {63'b0, stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'b0, busy}, 64'd0);

    // Reset mid-MUL discards the op and clears all outputs.
    @(posedge clk); #1;
    op = 2'd1; a = 32'd77; b = 32'd55; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", {63'b0, busy}, 64'd0);
    check("midrst_done", {63'b0, done}, 64'd0);
    check("midrst_lo", {32'b0, result_lo}, 64'd0);
    check("midrst_hi", {32'b0, result_hi}, 64'd0);
    check("midrst_dz", {63'b0, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    last_lo = '0; last_hi = '0; last_dz = 1'b0;

    // Randomized ops with a bias toward the corner cases.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int          sel;
      ro  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = '0;
      else if (sel == 1) rb = 32'($urandom_range(0, 15));
      else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 3) ra = 32'($urandom_range(0, 255));
      do_op(ro, ra, rb, 0);
    end

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
